// File: rtl/unary_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unary_pkg
// Description : Shared types and helpers for the unary shift-MAC datapath.
//               Holds the encoder state enum and the width helper used by
//               unary_encoder, unary_adder and their counters.
// Revision    : 1.0 - initial release
// ============================================================================
package unary_pkg;

    // Encoder frame states: waiting, payload window, trailing zero window.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        DRAIN = 2'd2
    } unary_enc_state_t;

    // Bits needed to hold any value in 0..max_val.
    function automatic int unary_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/unary_encoder.sv
`default_nettype none
// ============================================================================
// Module      : unary_encoder
// Description : Binary-to-unary front end. Accepts a binary operand over a
//               valid/ready handshake and emits it as a contiguous burst of
//               1s at the start of a fixed MAX+GAP cycle frame. Values above
//               MAX are clamped to MAX and flagged on sat for the frame.
// Ports       : clk          - clock, all state on rising edge
//               reset_n      - asynchronous active-low reset
//               in_valid     - in_value is presented
//               in_ready     - encoder accepts a value this cycle
//               in_value     - unsigned binary operand (W bits)
//               out          - registered unary stream bit
//               frame_start  - registered pulse on frame cycle 0
//               frame_done   - registered pulse on frame cycle MAX+GAP-1
//               sat          - accepted value was clamped (whole frame)
// Revision    : 1.0 - initial release
// ============================================================================
module unary_encoder
    import unary_pkg::*;
#(
    parameter int MAX = 16,
    parameter int GAP = 2,
    parameter int W   = unary_width(MAX)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_value,
    output logic         out,
    output logic         frame_start,
    output logic         frame_done,
    output logic         sat
);

    // Frame counter spans EMIT and DRAIN: 0..MAX+GAP-1.
    localparam int CW = unary_width(MAX + GAP - 1);

    localparam logic [W-1:0]  c_max        = W'(MAX);
    localparam logic [CW-1:0] c_emit_last  = CW'(MAX - 1);
    localparam logic [CW-1:0] c_frame_last = CW'(MAX + GAP - 1);

    unary_enc_state_t r_state;
    unary_enc_state_t w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [W-1:0]     r_val;
    logic [W-1:0]     w_val_nxt;
    logic             r_sat;
    logic             w_sat_nxt;
    logic             r_out;
    logic             w_out_nxt;
    logic             r_frame_start;
    logic             r_frame_done;
    logic             w_frame_done_nxt;

    logic             w_ready;
    logic             w_xfer;
    logic             w_over;
    logic [W-1:0]     w_clamped;

    // Ready depends on state only so a producer may wait on it freely.
    assign w_ready   = (r_state == IDLE) ||
                       ((r_state == DRAIN) && (r_cnt == c_frame_last));
    assign w_xfer    = in_valid && w_ready;
    assign w_over    = (in_value > c_max);
    assign w_clamped = w_over ? c_max : in_value;

    // Next-state logic. The registered outputs are computed from the next
    // state so that they line up with state/cnt: during frame cycle k the
    // FSM sits at cnt==k and out already shows bit k.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_val_nxt        = r_val;
        w_sat_nxt        = r_sat;
        w_out_nxt        = 1'b0;
        w_frame_done_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
            end
            EMIT: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == c_emit_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_cnt == c_frame_last) begin
                    // Falls back to IDLE unless a new transfer below
                    // overrides it with a bubble-free restart.
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_sat_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_sat_nxt   = 1'b0;
            end
        endcase

        if (w_xfer) begin
            w_state_nxt = EMIT;
            w_cnt_nxt   = '0;
            w_val_nxt   = w_clamped;
            w_sat_nxt   = w_over;
        end

        // Zero-extend both sides to a common width for the compare.
        if (w_state_nxt == EMIT) begin
            w_out_nxt = ({{W{1'b0}}, w_cnt_nxt} < {{CW{1'b0}}, w_val_nxt});
        end

        w_frame_done_nxt = (w_state_nxt == DRAIN) && (w_cnt_nxt == c_frame_last);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_val         <= '0;
            r_sat         <= 1'b0;
            r_out         <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_val         <= w_val_nxt;
            r_sat         <= w_sat_nxt;
            r_out         <= w_out_nxt;
            r_frame_start <= w_xfer;
            r_frame_done  <= w_frame_done_nxt;
        end
    end

    assign in_ready    = w_ready;
    assign out         = r_out;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign sat         = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_unary_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_unary_encoder
// Description : Self-checking bench for unary_encoder (MAX=16, GAP=2).
//               Directed vector table of single frames plus hand-written
//               back-to-back and mid-frame reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unary_encoder;

    localparam int MAX  = 16;
    localparam int GAP  = 2;
    localparam int W    = 5;
    localparam int FLEN = MAX + GAP;

    typedef struct {
        logic [W-1:0] value;
        int           ones;
        logic         sat;
    } vec_t;

    logic         clk      = 1'b0;
    logic         reset_n  = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_value = '0;
    logic         in_ready;
    logic         out;
    logic         frame_start;
    logic         frame_done;
    logic         sat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    unary_encoder #(
        .MAX(MAX),
        .GAP(GAP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .out        (out),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .sat        (sat)
    );

    // Observed bundle: {out, frame_start, frame_done, in_ready, sat}
    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present v and complete the handshake; returns at #1 after the edge.
    task automatic send(input logic [W-1:0] v);
        in_valid = 1'b1;
        in_value = v;
        @(negedge clk);
        check($sformatf("ready before send %0d", v), {4'b0, in_ready}, 5'b00001);
        @(posedge clk);
        #1;
    endtask

    // Check one full frame for value v. in_valid/in_value are held at
    // hold_valid/nxt for the whole frame, so a chained transfer happens on
    // the last cycle only.
    task automatic frame(input logic [W-1:0] v, input logic hold_valid, input logic [W-1:0] nxt);
        int clamped;
        int ones;
        logic exp_sat;
        clamped = (int'(v) > MAX) ? MAX : int'(v);
        exp_sat = (int'(v) > MAX);
        ones    = 0;
        for (int k = 0; k < FLEN; k++) begin
            in_valid = hold_valid;
            in_value = nxt;
            @(negedge clk);
            ones += int'(out);
            check($sformatf("frame v=%0d k=%0d", v, k),
                  {out, frame_start, frame_done, in_ready, sat},
                  {(k < clamped), (k == 0), (k == FLEN-1), (k == FLEN-1), exp_sat});
            @(posedge clk);
            #1;
        end
        check_int($sformatf("ones v=%0d", v), ones, clamped);
    endtask

    task automatic idle_check(input string name);
        in_valid = 1'b0;
        @(negedge clk);
        check(name, {out, frame_start, frame_done, in_ready, sat}, 5'b00010);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{value: 5'd5,  ones: 5,  sat: 1'b0};
        vecs[1] = '{value: 5'd0,  ones: 0,  sat: 1'b0};
        vecs[2] = '{value: 5'd16, ones: 16, sat: 1'b0};
        vecs[3] = '{value: 5'd31, ones: 16, sat: 1'b1};
        vecs[4] = '{value: 5'd17, ones: 16, sat: 1'b1};
        vecs[5] = '{value: 5'd1,  ones: 1,  sat: 1'b0};

        // Asynchronous reset: outputs clear before any clock edge.
        #1 reset_n = 1'b0;
        #2;
        check("async reset state", {out, frame_start, frame_done, in_ready, sat}, 5'b00010);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle_check("idle after reset");

        // Table-driven single frames, each followed by an idle cycle.
        foreach (vecs[i]) begin
            int ones;
            send(vecs[i].value);
            ones = 0;
            in_valid = 1'b0;
            for (int k = 0; k < FLEN; k++) begin
                @(negedge clk);
                ones += int'(out);
                check($sformatf("vec%0d k=%0d", i, k),
                      {out, frame_start, frame_done, in_ready, sat},
                      {(k < vecs[i].ones), (k == 0), (k == FLEN-1), (k == FLEN-1), vecs[i].sat});
                @(posedge clk);
                #1;
            end
            check_int($sformatf("vec%0d ones", i), ones, vecs[i].ones);
            idle_check($sformatf("vec%0d idle after frame", i));
        end

        // Back-to-back frames with in_valid held high: 3, 7, 2.
        send(5'd3);
        frame(5'd3, 1'b1, 5'd7);
        frame(5'd7, 1'b1, 5'd2);
        frame(5'd2, 1'b0, 5'd0);
        idle_check("idle after chain");

        // Saturated frame chained into an unsaturated one: sat must drop.
        send(5'd30);
        frame(5'd30, 1'b1, 5'd4);
        frame(5'd4, 1'b0, 5'd0);
        idle_check("idle after sat chain");

        // Mid-frame reset at frame cycle 4 of value 10.
        send(5'd10);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("pre-reset k=%0d", k),
                  {out, frame_start, frame_done, in_ready, sat},
                  {1'b1, (k == 0), 1'b0, 1'b0, 1'b0});
            if (k < 4) begin
                @(posedge clk);
                #1;
            end
        end
        #2 reset_n = 1'b0;
        #1;
        check("async mid-frame reset", {out, frame_start, frame_done, in_ready, sat}, 5'b00010);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < FLEN; k++) begin
            idle_check($sformatf("abandoned frame idle %0d", k));
        end
        send(5'd2);
        frame(5'd2, 1'b0, 5'd0);
        idle_check("idle after reset frame");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
